// File: rtl/cache_pkg.sv
// cache_pkg: state encoding and tree pseudo-LRU helpers shared by the
// N-way cache tag array (supports up to 8 ways).
package cache_pkg;

    typedef enum logic [1:0] {
        CT_INIT,
        CT_LOOKUP,
        CT_MISS
    } ct_state_e;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit=0 steers the
    // victim to the left subtree, bit=1 to the right. Way MSB picks at the root.
    function automatic logic [7:0] plru_next(
        input logic [7:0] bits,
        input logic [2:0] way,
        input int         lvls
    );
        logic [7:0] nb;
        logic [2:0] aw;
        logic [2:0] n;
        logic       d;
        nb = bits;
        aw = way << (3 - lvls);
        n  = '0;
        for (int l = 0; l < 3; l++) begin
            if (l < lvls) begin
                d     = aw[2];
                nb[n] = ~d;
                n     = {n[1:0], 1'b0} + 3'd1 + {2'b00, d};
                aw    = aw << 1;
            end
        end
        return nb;
    endfunction

    function automatic logic [2:0] plru_victim(
        input logic [7:0] bits,
        input int         lvls
    );
        logic [2:0] n;
        logic [2:0] w;
        logic       d;
        n = '0;
        w = '0;
        for (int l = 0; l < 3; l++) begin
            if (l < lvls) begin
                d = bits[n];
                w = {w[1:0], d};
                n = {n[1:0], 1'b0} + 3'd1 + {2'b00, d};
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// cache_plru_tree: combinational tree-PLRU update and victim select for
// one set; one instance per lookup port.
module cache_plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         bits_i,
    input  logic [$clog2(WAYS)-1:0] way_i,
    output logic [WAYS-2:0]         next_o,
    output logic [$clog2(WAYS)-1:0] vidx_o,
    output logic [WAYS-1:0]         victim_o
);
    localparam int LVLS = $clog2(WAYS);

    logic [8-WAYS:0] pad_unused;
    logic [2:0]      vidx3;

    assign {pad_unused, next_o} = plru_next(8'(bits_i), 3'(way_i), LVLS);
    assign vidx3    = plru_victim(8'(bits_i), LVLS);
    assign vidx_o   = LVLS'(vidx3);
    assign victim_o = WAYS'(1) << vidx_o;

endmodule

// File: rtl/cache_tag_nway.sv
// cache_tag_nway: N-way tag/state array with tree PLRU, post-reset valid
// sweep and latched miss FSM. Define CACHE_TAG_STAT_EN for hit/miss counters.
module cache_tag_nway
    import cache_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cached,
    input  logic              req_en,
    input  logic [3:0]        req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              refresh,
    input  logic              invalidate,
    output logic              init_done,
    output logic              stallreq,
    output logic              miss,
    output logic [ADDR_W-1:0] axi_raddr,
    output logic              write_back,
    output logic [ADDR_W-1:0] axi_waddr,
    output logic [WAYS-1:0]   hit,
    output logic [WAYS-1:0]   victim
`ifdef CACHE_TAG_STAT_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);
    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W    = $clog2(WAYS);

    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAYS-2:0]    plru_q  [SETS];

    ct_state_e          state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic               init_q, init_d;
    logic [INDEX_W-1:0] midx_q, midx_d;
    logic [TAG_W-1:0]   mtag_q, mtag_d;
    logic [WAY_W-1:0]   mway_q, mway_d;
    logic               mdirty_q, mdirty_d;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx, rd_idx;
    logic [WAYS-1:0]    vld, drt, hit_c, vict_oh, tree_oh;
    logic [WAYS-2:0]    plru_cur, plru_nxt;
    logic [WAY_W-1:0]   hit_way, inv_way, tree_way, vict_way, upd_way;
    logic               in_init, in_lookup, in_miss;
    logic               any_hit, any_inv, lk_miss;
    logic               do_fill, do_hit_upd, do_store, do_inval;

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx   = req_addr[OFFSET_W +: INDEX_W];
    assign in_init   = state_q == CT_INIT;
    assign in_lookup = state_q == CT_LOOKUP;
    assign in_miss   = state_q == CT_MISS;

    // While a miss is outstanding the array is read at the latched set.
    assign rd_idx   = in_miss ? midx_q : req_idx;
    assign vld      = valid_q[rd_idx];
    assign drt      = dirty_q[rd_idx];
    assign plru_cur = plru_q[rd_idx];

    always_comb begin
        hit_c   = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_c[w] = in_lookup & req_en & cached & vld[w]
                     & (tag_q[w][rd_idx] == req_tag);
            if (hit_c[w]) hit_way = WAY_W'(w);
            if (!vld[w])  inv_way = WAY_W'(w);
        end
    end

    assign any_hit  = |hit_c;
    assign any_inv  = ~&vld;
    assign lk_miss  = in_lookup & req_en & cached & ~any_hit;
    assign vict_way = any_inv ? inv_way : tree_way;
    assign vict_oh  = any_inv ? (WAYS'(1) << inv_way) : tree_oh;
    assign upd_way  = in_miss ? mway_q : hit_way;

    cache_plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_i   (plru_cur),
        .way_i    (upd_way),
        .next_o   (plru_nxt),
        .vidx_o   (tree_way),
        .victim_o (tree_oh)
    );

    assign do_inval   = any_hit & invalidate;
    assign do_hit_upd = any_hit & ~invalidate;
    assign do_store   = do_hit_upd & (|req_wen);
    assign do_fill    = in_miss & refresh;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        init_d   = init_q;
        midx_d   = midx_q;
        mtag_d   = mtag_q;
        mway_d   = mway_q;
        mdirty_d = mdirty_q;
        unique case (state_q)
            CT_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INDEX_W'(SETS - 1)) begin
                    state_d = CT_LOOKUP;
                    init_d  = 1'b1;
                end
            end
            CT_LOOKUP: begin
                if (lk_miss) begin
                    state_d  = CT_MISS;
                    midx_d   = req_idx;
                    mtag_d   = req_tag;
                    mway_d   = vict_way;
                    mdirty_d = |req_wen;
                end
            end
            CT_MISS: begin
                if (refresh) state_d = CT_LOOKUP;
            end
            default: state_d = CT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CT_INIT;
            cnt_q    <= '0;
            init_q   <= 1'b0;
            midx_q   <= '0;
            mtag_q   <= '0;
            mway_q   <= '0;
            mdirty_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            midx_q   <= midx_d;
            mtag_q   <= mtag_d;
            mway_q   <= mway_d;
            mdirty_q <= mdirty_d;
        end
    end

    // Array storage carries no reset; the INIT sweep clears valid and PLRU.
    always_ff @(posedge clk) begin
        if (in_init) begin
            valid_q[cnt_q] <= '0;
            plru_q[cnt_q]  <= '0;
        end
        if (do_hit_upd | do_fill) plru_q[rd_idx] <= plru_nxt;
        if (do_store) dirty_q[rd_idx][hit_way] <= 1'b1;
        if (do_inval) begin
            valid_q[rd_idx][hit_way] <= 1'b0;
            dirty_q[rd_idx][hit_way] <= 1'b0;
        end
        if (do_fill) begin
            tag_q[mway_q][midx_q]   <= mtag_q;
            valid_q[midx_q][mway_q] <= 1'b1;
            dirty_q[midx_q][mway_q] <= mdirty_q;
        end
    end

    assign hit        = hit_c;
    assign miss       = lk_miss | in_miss;
    assign stallreq   = in_init | in_miss | lk_miss;
    assign init_done  = init_q;
    assign victim     = in_miss   ? (WAYS'(1) << mway_q)
                      : in_lookup ? vict_oh : '0;
    assign write_back = in_miss & vld[mway_q] & drt[mway_q];
    assign axi_waddr  = in_miss
                      ? {tag_q[mway_q][midx_q], midx_q, {OFFSET_W{1'b0}}}
                      : '0;
    assign axi_raddr  = in_miss ? {mtag_q, midx_q, {OFFSET_W{1'b0}}}
                      : cached  ? {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}}
                      : req_addr;

`ifdef CACHE_TAG_STAT_EN
    logic [31:0] hits_q, hits_d, misses_q, misses_d;

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (any_hit & ~&hits_q)   hits_d   = hits_q + 32'd1;
        if (lk_miss & ~&misses_q) misses_d = misses_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_tag_nway.sv
// Directed bench for cache_tag_nway, default build (4 ways, 128 sets,
// 32-byte lines): index 0 is tags 0x1000, 0x2000, ... with zero offset.
module tb_cache_tag_nway;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cached;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic        refresh;
    logic        invalidate;
    logic        init_done;
    logic        stallreq;
    logic        miss;
    logic [31:0] axi_raddr;
    logic        write_back;
    logic [31:0] axi_waddr;
    logic [3:0]  hit;
    logic [3:0]  victim;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cache_tag_nway dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cached     (cached),
        .req_en     (req_en),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .refresh    (refresh),
        .invalidate (invalidate),
        .init_done  (init_done),
        .stallreq   (stallreq),
        .miss       (miss),
        .axi_raddr  (axi_raddr),
        .write_back (write_back),
        .axi_waddr  (axi_waddr),
        .hit        (hit),
        .victim     (victim)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] wen);
        req_en   = 1'b1;
        cached   = 1'b1;
        req_addr = a;
        req_wen  = wen;
        #1;
    endtask

    // Miss on a, refill, then check the re-presented access and next victim.
    task automatic do_fill(input logic [31:0] a, input logic [3:0] vic,
                           input logic [3:0] nvic, input string tag);
        load(a, 4'h0);
        chk({tag, " miss"}, miss, 1);
        chk({tag, " victim"}, victim, vic);
        tick();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        #1;
        chk({tag, " hit"}, hit, vic);
        chk({tag, " next_victim"}, victim, nvic);
        tick();
        req_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        cached     = 1'b0;
        req_en     = 1'b0;
        req_wen    = 4'h0;
        req_addr   = 32'h0;
        refresh    = 1'b0;
        invalidate = 1'b0;
        #12;
        chk("rst stallreq", stallreq, 1);
        chk("rst init_done", init_done, 0);
        chk("rst miss", miss, 0);
        chk("rst hit", hit, 0);
        chk("rst victim", victim, 0);
        chk("rst write_back", write_back, 0);
        chk("rst axi_waddr", axi_waddr, 0);

        // Sweep: 128 cycles of INIT; a pending load is ignored meanwhile.
        req_en   = 1'b1;
        cached   = 1'b1;
        req_addr = 32'h0000_1000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (127) tick();
        chk("init c127 init_done", init_done, 0);
        chk("init c127 stallreq", stallreq, 1);
        chk("init c127 miss", miss, 0);
        tick();
        chk("init c128 init_done", init_done, 1);
        chk("init c128 miss", miss, 1);
        chk("init c128 victim", victim, 4'b0001);

        // Fill ways 0..3 of set 0 in order (invalid-first).
        do_fill(32'h0000_1000, 4'b0001, 4'b0010, "fill1");
        do_fill(32'h0000_2000, 4'b0010, 4'b0100, "fill2");
        do_fill(32'h0000_3000, 4'b0100, 4'b1000, "fill3");
        do_fill(32'h0000_4000, 4'b1000, 4'b0001, "fill4");

        // Dirty way0, then touch ways 1 and 2 so PLRU points back at way0.
        load(32'h0000_1004, 4'hF);
        chk("store hit", hit, 4'b0001);
        chk("store stallreq", stallreq, 0);
        tick();
        load(32'h0000_2000, 4'h0);
        chk("touch2 hit", hit, 4'b0010);
        tick();
        load(32'h0000_3000, 4'h0);
        chk("touch3 hit", hit, 4'b0100);
        tick();

        load(32'h0000_5008, 4'h0);
        chk("evict miss", miss, 1);
        chk("evict victim", victim, 4'b0001);
        chk("evict lookup raddr", axi_raddr, 32'h0000_5000);
        tick();
        chk("evict write_back", write_back, 1);
        chk("evict axi_waddr", axi_waddr, 32'h0000_1000);
        chk("evict axi_raddr", axi_raddr, 32'h0000_5000);
        chk("evict hold victim", victim, 4'b0001);
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        #1;
        chk("evict refill hit", hit, 4'b0001);
        chk("evict refill write_back", write_back, 0);
        chk("evict refill victim", victim, 4'b1000);
        tick();

        // Uncached access passes straight through.
        req_addr = 32'hBFC0_0004;
        cached   = 1'b0;
        #1;
        chk("uc hit", hit, 0);
        chk("uc miss", miss, 0);
        chk("uc stallreq", stallreq, 0);
        chk("uc axi_raddr", axi_raddr, 32'hBFC0_0004);
        tick();
        load(32'h0000_2000, 4'h0);
        chk("post uc hit", hit, 4'b0010);
        tick();

        // Invalidate way1, then the same line misses into way1.
        invalidate = 1'b1;
        #1;
        chk("inval hit", hit, 4'b0010);
        chk("inval stallreq", stallreq, 0);
        tick();
        invalidate = 1'b0;
        #1;
        chk("after inval hit", hit, 0);
        chk("after inval miss", miss, 1);
        chk("after inval victim", victim, 4'b0010);
        tick();

        // Latched miss outputs hold while the request wanders.
        req_addr = 32'hDEAD_BEE0;
        repeat (10) tick();
        chk("hold axi_raddr", axi_raddr, 32'h0000_2000);
        chk("hold victim", victim, 4'b0010);
        chk("hold miss", miss, 1);
        chk("hold write_back", write_back, 0);

        // Reset mid-miss drops it at once and reruns the sweep.
        rst_n = 1'b0;
        #1;
        chk("midmiss rst miss", miss, 0);
        chk("midmiss rst stallreq", stallreq, 1);
        chk("midmiss rst init_done", init_done, 0);
        req_addr = 32'h0000_5000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (128) tick();
        chk("resweep init_done", init_done, 1);
        chk("resweep miss", miss, 1);
        chk("resweep victim", victim, 4'b0001);

        if (failed != 0) $display("%0d comparisons did not match", failed);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
